// File: rtl/blit_pkg.sv
// Shared types and default geometry for the sprite blitter.
package blit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } blit_state_t;

  localparam int BLIT_ADDR_W  = 19;
  localparam int BLIT_COLOR_W = 12;
  localparam int BLIT_FB_W    = 640;
  localparam int BLIT_FB_H    = 480;

  localparam logic [BLIT_COLOR_W-1:0] BLIT_TRANSPARENT_KEY = 12'h000;

  // Start-of-row offset for the first destination row; later rows are accumulated.
  function automatic int row_offset(input logic [8:0] y, input int stride);
    return int'({23'd0, y}) * stride;
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Raster walker: column/row counters, incremental ROM address and destination row base.
// Outputs describe the pixel whose ROM read is presented this cycle.
module blit_addr_gen
  import blit_pkg::*;
#(
  parameter int ADDR_W  = BLIT_ADDR_W,
  parameter int FB_W    = BLIT_FB_W,
  parameter int FB_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [9:0]        posx,
  input  logic [8:0]        posy,
  input  logic [9:0]        width,
  input  logic [8:0]        height,
  input  logic              mirror,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              pix_vld,
  output logic [10:0]       pix_x,
  output logic [10:0]       pix_y,
  output logic [ADDR_W-1:0] row_base,
  output logic              last
);

  logic [9:0]        i;
  logic [8:0]        j;
  logic [9:0]        w_q;
  logic [8:0]        h_q;
  logic [10:0]       posx_q;
  logic              mirror_q;
  logic [ADDR_W-1:0] row_src;
  logic [ADDR_W-1:0] next_row_src;
  logic              row_end;

  assign row_end      = (i == w_q - 10'd1);
  assign last         = pix_vld && row_end && (j == h_q - 9'd1);
  assign next_row_src = row_src + ADDR_W'(w_q);

  // Row-major source with stride == width: unmirrored reads are simply +1 every pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i        <= '0;
      j        <= '0;
      w_q      <= '0;
      h_q      <= '0;
      posx_q   <= '0;
      mirror_q <= 1'b0;
      row_src  <= '0;
      rom_addr <= '0;
      pix_vld  <= 1'b0;
      pix_x    <= '0;
      pix_y    <= '0;
      row_base <= '0;
    end else if (load) begin
      i        <= '0;
      j        <= '0;
      w_q      <= width;
      h_q      <= height;
      posx_q   <= {1'b0, posx};
      mirror_q <= mirror;
      row_src  <= src;
      rom_addr <= mirror ? src + ADDR_W'(width) - ADDR_W'(1) : src;
      pix_vld  <= (width != 10'd0) && (height != 9'd0);
      pix_x    <= {1'b0, posx};
      pix_y    <= {2'b00, posy};
      row_base <= ADDR_W'(FB_BASE + row_offset(posy, FB_W));
    end else if (step) begin
      pix_vld <= 1'b1;
      if (row_end) begin
        i        <= '0;
        j        <= j + 9'd1;
        row_src  <= next_row_src;
        rom_addr <= mirror_q ? next_row_src + ADDR_W'(w_q) - ADDR_W'(1) : next_row_src;
        pix_x    <= posx_q;
        pix_y    <= pix_y + 11'd1;
        row_base <= row_base + ADDR_W'(FB_W);
      end else begin
        i        <= i + 10'd1;
        rom_addr <= mirror_q ? rom_addr - ADDR_W'(1) : rom_addr + ADDR_W'(1);
        pix_x    <= pix_x + 11'd1;
      end
    end else begin
      pix_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: streams ROM pixels into the frame buffer with clipping and colour-key.
// Define SPRITE_BLITTER_MIRROR_EN to add cmd_mirror for horizontal flips.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int                   ADDR_W          = BLIT_ADDR_W,
  parameter int                   COLOR_W         = BLIT_COLOR_W,
  parameter int                   FB_W            = BLIT_FB_W,
  parameter int                   FB_H            = BLIT_FB_H,
  parameter int                   FB_BASE         = 0,
  parameter logic [COLOR_W-1:0]   TRANSPARENT_KEY = BLIT_TRANSPARENT_KEY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_posx,
  input  logic [8:0]         cmd_posy,
  input  logic [9:0]         cmd_width,
  input  logic [8:0]         cmd_height,
  input  logic [ADDR_W-1:0]  cmd_src_addr,
`ifdef SPRITE_BLITTER_MIRROR_EN
  input  logic               cmd_mirror,
`endif
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  output logic               done
);

  blit_state_t       state;
  logic              handshake;
  logic              step;
  logic              mirror;
  logic              pix_vld;
  logic [10:0]       pix_x;
  logic [10:0]       pix_y;
  logic [ADDR_W-1:0] row_base;
  logic              last;

  logic              s1_vld;
  logic [10:0]       s1_x;
  logic [10:0]       s1_y;
  logic [ADDR_W-1:0] s1_base;

`ifdef SPRITE_BLITTER_MIRROR_EN
  assign mirror = cmd_mirror;
`else
  assign mirror = 1'b0;
`endif

  assign handshake = (state == IDLE) && cmd_valid && cmd_ready;
  assign step      = (state == RUN) && !last;

  blit_addr_gen #(
    .ADDR_W  (ADDR_W),
    .FB_W    (FB_W),
    .FB_BASE (FB_BASE)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (handshake),
    .step     (step),
    .src      (cmd_src_addr),
    .posx     (cmd_posx),
    .posy     (cmd_posy),
    .width    (cmd_width),
    .height   (cmd_height),
    .mirror   (mirror),
    .rom_addr (rom_addr),
    .pix_vld  (pix_vld),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .row_base (row_base),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (handshake) begin
            cmd_ready <= 1'b0;
            state     <= (cmd_width == 10'd0 || cmd_height == 9'd0) ? FINISH : RUN;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RUN: begin
          if (last) state <= DRAIN;
        end
        // Once the read stage is empty, the final pixel sits in s1 and writes on this edge.
        DRAIN: begin
          if (!pix_vld) state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 lines the pixel tag up with rom_data, which arrives one cycle after rom_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_base <= '0;
    end else begin
      s1_vld  <= pix_vld;
      s1_x    <= pix_x;
      s1_y    <= pix_y;
      s1_base <= row_base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else begin
      fb_we    <= s1_vld && (s1_x < 11'(FB_W)) && (s1_y < 11'(FB_H)) &&
                  (rom_data != TRANSPARENT_KEY);
      fb_addr  <= s1_base + ADDR_W'(s1_x);
      fb_wdata <= rom_data;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: table of blits checked by a write scoreboard, plus back-pressure and reset sequences.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_posx = '0;
  logic [8:0]  cmd_posy = '0;
  logic [9:0]  cmd_width = '0;
  logic [8:0]  cmd_height = '0;
  logic [18:0] cmd_src_addr = '0;
  logic [18:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_wdata;
  logic        done;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_posx     (cmd_posx),
    .cmd_posy     (cmd_posy),
    .cmd_width    (cmd_width),
    .cmd_height   (cmd_height),
    .cmd_src_addr (cmd_src_addr),
`ifdef SPRITE_BLITTER_MIRROR_EN
    .cmd_mirror   (1'b0),
`endif
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .done         (done)
  );

  typedef struct {
    int posx; int posy; int w; int h; int src;
    int zero_addr; int watch; int exp_writes; int exp_done;
  } vec_t;

  typedef struct { int addr; int data; } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_writes = 0;
  int  watch_addr = -1;
  int  watch_hits = 0;
  int  zero_addr = -1;

  function automatic logic [11:0] rom_word(input int a);
    logic [7:0] lo;
    lo = a[7:0];
    if (a == zero_addr) return 12'h000;
    return {lo, 4'hA};
  endfunction

  always @(posedge clk) rom_data <= rom_word(int'(rom_addr));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && fb_we) begin
      wr_t e;
      n_writes++;
      if (int'(fb_addr) == watch_addr) watch_hits++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d, expected no write", fb_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(fb_addr), e.addr);
        check("wr_data", int'(fb_wdata), e.data);
      end
    end
  end

  task automatic push_expect(input int px, input int py, input int w, input int h, input int src);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) begin
        wr_t e;
        int x = px + i;
        int y = py + j;
        logic [11:0] d = rom_word(src + j * w + i);
        if (x < 640 && y < 480 && d != 12'h000) begin
          e.addr = y * 640 + x;
          e.data = int'(d);
          exp_q.push_back(e);
        end
      end
  endtask

  task automatic drive_cmd(input int px, input int py, input int w, input int h, input int src);
    cmd_posx     = 10'(px);
    cmd_posy     = 9'(py);
    cmd_width    = 10'(w);
    cmd_height   = 9'(h);
    cmd_src_addr = 19'(src);
  endtask

  task automatic run_cmd(input vec_t v, output int lat, output int nwr,
                         output int first_wr, output int rdy_bad);
    zero_addr  = v.zero_addr;
    watch_addr = v.watch;
    watch_hits = 0;
    push_expect(v.posx, v.posy, v.w, v.h, v.src);
    @(negedge clk);
    drive_cmd(v.posx, v.posy, v.w, v.h, v.src);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drive_cmd(0, 0, 0, 0, 0);
    lat = -1; nwr = 0; first_wr = -1; rdy_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (fb_we) begin
        nwr++;
        if (first_wr < 0) first_wr = k;
      end
      if (done) begin
        lat = k;
        break;
      end
      if (cmd_ready) rdy_bad++;
    end
  endtask

  vec_t vecs[9];
  int lat, nwr, first_wr, rdy_bad, wr0, done_cnt;

  initial begin
    vecs[0] = '{10, 5, 4, 2, 100, -1, -1, 8, 11};
    vecs[1] = '{10, 5, 4, 2, 100, 102, 3212, 7, 11};
    vecs[2] = '{638, 479, 4, 3, 200, -1, -1, 2, 15};
    vecs[3] = '{5, 5, 0, 3, 0, -1, -1, 0, 2};
    vecs[4] = '{5, 5, 3, 0, 0, -1, -1, 0, 2};
    vecs[5] = '{700, 10, 3, 2, 300, -1, -1, 0, 9};
    vecs[6] = '{637, 0, 3, 1, 400, -1, -1, 3, 6};
    vecs[7] = '{0, 478, 1, 3, 500, -1, -1, 2, 6};
    vecs[8] = '{639, 479, 1, 1, 600, -1, -1, 1, 4};

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_done", int'(done), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_wdata", int'(fb_wdata), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 9; n++) begin
      run_cmd(vecs[n], lat, nwr, first_wr, rdy_bad);
      check($sformatf("v%0d_done_latency", n), lat, vecs[n].exp_done);
      check($sformatf("v%0d_write_count", n), nwr, vecs[n].exp_writes);
      check($sformatf("v%0d_ready_while_busy", n), rdy_bad, 0);
      check($sformatf("v%0d_watch_hits", n), watch_hits, 0);
      check($sformatf("v%0d_queue_left", n), exp_q.size(), 0);
      if (vecs[n].exp_writes > 0 && vecs[n].posx < 640 && vecs[n].posy < 480 && vecs[n].zero_addr < 0)
        check($sformatf("v%0d_first_write_cycle", n), first_wr, 3);
      @(negedge clk);
      check($sformatf("v%0d_done_width", n), int'(done), 0);
      check($sformatf("v%0d_ready_after_done", n), int'(cmd_ready), 1);
      exp_q.delete();
    end
    zero_addr = -1;
    watch_addr = -1;

    // Second command held pending while the first runs.
    push_expect(10, 5, 4, 2, 100);
    push_expect(50, 60, 2, 2, 700);
    @(negedge clk);
    drive_cmd(10, 5, 4, 2, 100);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 drive_cmd(50, 60, 2, 2, 700);
    lat = -1; rdy_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (cmd_ready) rdy_bad++;
    end
    check("bp_first_done", lat, 11);
    check("bp_ready_low", rdy_bad, 0);
    check("bp_ready_in_done_cycle", int'(cmd_ready), 0);
    check("bp_queue_after_first", exp_q.size(), 4);
    @(negedge clk);
    check("bp_ready_after_done", int'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    check("bp_second_done", lat, 7);
    check("bp_queue_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);

    // Reset while pixel 3 of a 4x4 blit is being read.
    push_expect(20, 20, 4, 4, 800);
    wr0 = n_writes;
    @(negedge clk);
    drive_cmd(20, 20, 4, 4, 800);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_fb_we", int'(fb_we), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check("mid_rst_writes_before", n_writes - wr0, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    run_cmd('{20, 20, 2, 2, 900, -1, -1, 4, 7}, lat, nwr, first_wr, rdy_bad);
    check("post_rst_done_latency", lat, 7);
    check("post_rst_write_count", nwr, 4);
    check("post_rst_first_write", first_wr, 3);
    check("post_rst_queue_left", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
